armleocpu_muldiv: RTL

//  Iterative RV M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands.

---
 rtl/armleocpu_muldiv_if.sv | 24 ++
 rtl/armleocpu_muldiv.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/armleocpu_muldiv_if.sv
// Request/response bundle between the execute stage (master) and the
// M-extension unit (slave).
interface armleocpu_muldiv_if #(
   parameter int XLEN = 32
);
   logic            valid;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            kill;
   logic            busy;
   logic            ready;
   logic [XLEN-1:0] result;

   modport master (
      output valid, op, rs1, rs2, kill,
      input  busy, ready, result
   );

   modport slave (
      input  valid, op, rs1, rs2, kill,
      output busy, ready, result
   );
endinterface

// File: rtl/armleocpu_muldiv.sv
// Iterative RV M-extension unit: shift-add multiplier and restoring divider sharing one accumulator.
// Optional macro ARMLEOCPU_MULDIV_FAST_MUL_EN: single-cycle multiplier, MUL* ops go IDLE->DONE.
module armleocpu_muldiv #(
   parameter int XLEN = 32
) (
   input logic               clk,
   input logic               rst_n,
   armleocpu_muldiv_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   localparam int AW = 2 * XLEN + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   counter;
   logic [2:0]      op_q;
   logic            neg_lo;
   logic            neg_hi;
   logic [XLEN-1:0] operand;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   acc_step;
   logic [XLEN-1:0] result_q;
   logic [XLEN-1:0] result_fix;

   logic            accept;
   logic            last;
   logic            sign1;
   logic            sign2;
   logic            neg1;
   logic            neg2;
   logic [XLEN-1:0] mag1;
   logic [XLEN-1:0] mag2;
   logic            div_zero;
   logic            div_ovf;
   logic            special;
   logic            skip_fix;
   logic [XLEN-1:0] special_val;
   logic [AW-1:0]   mul_init;
   state_t          mul_state;

   logic [XLEN:0]     mul_sum;
   logic [AW-1:0]     shifted;
   logic [XLEN+1:0]   trial;
   logic [2*XLEN-1:0] prod_fix;

   assign accept = (state == S_IDLE) && bus.valid && !bus.kill;
   assign last   = (counter == CW'(XLEN - 1));

   // Operand signedness, magnitudes and the divide corner cases, decoded from the live request.
   // NOTE: every always_comb output gets a default on all paths so no latch is inferred.
   always_comb begin
      sign1    = (bus.op != 3'b011) && (bus.op != 3'b101) && (bus.op != 3'b111);
      sign2    = sign1 && (bus.op != 3'b010);
      neg1     = sign1 && bus.rs1[XLEN-1];
      neg2     = sign2 && bus.rs2[XLEN-1];
      mag1     = neg1 ? -bus.rs1 : bus.rs1;
      mag2     = neg2 ? -bus.rs2 : bus.rs2;
      div_zero = (bus.rs2 == '0);
      div_ovf  = sign2 && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2);
      special  = bus.op[2] && (div_zero || div_ovf);
      if (div_zero) special_val = bus.op[1] ? bus.rs1 : '1;
      else          special_val = bus.op[1] ? '0 : bus.rs1;
   end

`ifdef ARMLEOCPU_MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;

   // Sign-extending by neg1/neg2 gives signed or unsigned operands as the op requires.
   assign fast_prod = (2*XLEN)'($signed({neg1, bus.rs1}) * $signed({neg2, bus.rs2}));
   assign mul_init  = {1'b0, fast_prod};
   assign mul_state = S_DONE;
   assign skip_fix  = special || !bus.op[2];
`else
   assign mul_init  = {{(XLEN+1){1'b0}}, mag2};
   assign mul_state = S_MUL;
   assign skip_fix  = special;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:       if (accept) state_next = bus.op[2] ? (special ? S_DONE : S_DIV) : mul_state;
         S_MUL, S_DIV: if (last) state_next = S_DONE;
         S_DONE:       state_next = S_IDLE;
         default:      state_next = S_IDLE;
      endcase
      if (bus.kill && (state != S_IDLE)) state_next = S_IDLE;
   end

   // One iteration step: multiply adds the multiplicand on the low bit then shifts right;
   // divide shifts left and keeps the trial subtraction when it does not borrow.
   always_comb begin
      mul_sum = acc[AW-1:XLEN] + (acc[0] ? {1'b0, operand} : '0);
      shifted = {acc[AW-2:0], 1'b0};
      trial   = {1'b0, shifted[AW-1:XLEN]} - {2'b0, operand};
      if (state == S_MUL)      acc_step = {1'b0, mul_sum, acc[XLEN-1:1]};
      else if (trial[XLEN+1])  acc_step = shifted;
      else                     acc_step = {trial[XLEN:0], shifted[XLEN-1:1], 1'b1};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         counter  <= '0;
         result_q <= '0;
      end else begin
         if (accept)                                   counter <= '0;
         else if ((state == S_MUL) || (state == S_DIV)) counter <= counter + CW'(1);
         if ((state == S_DONE) && !bus.kill)           result_q <= result_fix;
      end
   end

   // NOTE: datapath registers carry no reset; all of them are loaded at accept before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q    <= bus.op;
         operand <= bus.op[2] ? mag2 : mag1;
         neg_lo  <= !skip_fix && (neg1 ^ neg2);
         neg_hi  <= !skip_fix && neg1;
         if (special)        acc <= {1'b0, special_val, special_val};
         else if (bus.op[2]) acc <= {{(XLEN+1){1'b0}}, mag1};
         else                acc <= mul_init;
      end else if ((state == S_MUL) || (state == S_DIV)) begin
         acc <= acc_step;
      end
   end

   // Sign fix-up: the full product is negated before the half select; remainder follows dividend.
   always_comb begin
      prod_fix = neg_lo ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
      case (op_q)
         3'b000:                 result_fix = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: result_fix = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         result_fix = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
         default:                result_fix = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      endcase
   end

   assign bus.busy   = (state != S_IDLE);
   assign bus.ready  = (state == S_DONE) && !bus.kill;
   assign bus.result = (state == S_DONE) ? result_fix : result_q;
endmodule
